alu_operand_select: RTL and testbench
=====================================

Name: alu_operand_select

Overview:
Parametrised, registered successor to the single-operand ALU source mux. Selects both ALU operands (A and B) from NUM_SRC flattened WIDTH-bit sources, with an optional operand swap. Results are buffered in a 2-entry skid FIFO with valid/ready handshakes on both sides. Sits between register-file/immediate logic and the ALU, and decouples decode stalls from ALU back-pressure.

Parameters:
WIDTH, 16, operand width in bits
NUM_SRC, 4, number of selectable sources (>=2)
SEL_W, $clog2(NUM_SRC+1), select field width; always holds index NUM_SRC

Ports:
CLK  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
SrcData  input  NUM_SRC*WIDTH  source i at bits [i*WIDTH +: WIDTH]
ResultIn  input  WIDTH  last ALU result, used only with the bypass feature
SelA  input  SEL_W  source index for operand A
SelB  input  SEL_W  source index for operand B
Swap  input  1  exchange A and B after selection
InValid  input  1  request valid
InReady  output  1  buffer can accept a request
OutA  output  WIDTH  operand A at the head entry
OutB  output  WIDTH  operand B at the head entry
OutValid  output  1  head entry valid
OutReady  input  1  ALU consumes the head entry
SelErr  output  1  sticky out-of-range select flag
ErrClr  input  1  synchronous clear of SelErr

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on Reset_n. All state clears on Reset_n low, regardless of any transfer in progress.
- Reset values: count=0, OutA=0, OutB=0, OutValid=0, SelErr=0. InReady=1 after reset.
- Selection is combinational on the inputs present when InValid && InReady.
  - Index < NUM_SRC: select SrcData slice.
  - Index == NUM_SRC: select ResultIn if OPSEL_BYPASS_EN is defined; otherwise treat as out-of-range.
  - Out-of-range index: operand = 0, and the value is still accepted.
  - Swap=1: the stored entry has A and B exchanged.
- Storage is a 2-entry FIFO (head and skid registers) with count 0..2.
  - InReady = (count < 2). It is a registered-state function only, with no combinational path from OutReady.
  - OutValid = (count > 0). OutA/OutB come straight from the head register.
- Transfers:
  - Push occurs when InValid && InReady. Pop occurs when OutValid && OutReady.
  - Latency: a push into an empty buffer shows OutValid=1 on the next cycle. There is no same-cycle pass-through.
  - Push and pop in the same cycle with count=1: the head is replaced by the new entry and count stays 1.
  - Push with count=0 writes the head. Push with count=1 and no pop writes the skid register.
  - Pop with count=2 moves skid to head.
  - count=2 means InReady=0, so no push can occur. Any pop still proceeds.
  - Pop with count=0 is impossible because OutValid=0.
- Ordering is strictly FIFO, and operands are never lost or duplicated.
- OutA/OutB hold their last value when count becomes 0. Only OutValid drops.
- SelErr:
  - Sets on the cycle after any accepted push containing an out-of-range SelA or SelB.
  - ErrClr clears it on the next edge.
  - If a set and a clear occur in the same cycle, set wins.
- Under back-pressure, inputs must be held by the upstream side. The block does not sample while InReady=0.

Optional Feature:
OPSEL_BYPASS_EN.
- Defined: index NUM_SRC selects ResultIn, which is sampled at the push edge. That index is not an error.
- Undefined: ResultIn is ignored, and index NUM_SRC yields operand 0 and sets SelErr.
- Port list is identical in both builds.

Test Plan:
1. Reset mid-stream: count=2, assert Reset_n=0 asynchronously -> OutValid=0, OutA=OutB=0, SelErr=0 immediately; InReady=1 after release.
2. Basic select: SrcData={0x3333,0x2222,0x1111,0x0000}, SelA=2, SelB=1, Swap=0, OutReady=1 -> next cycle OutValid=1, OutA=0x2222, OutB=0x1111. Repeat with Swap=1 -> OutA=0x1111, OutB=0x2222.
3. Back-pressure: OutReady=0, push 3 requests (Sel 0/1, 1/2, 2/3) -> InReady=0 after the 2nd push, 3rd held. Release OutReady -> outputs in order (0x0000/0x1111), (0x1111/0x2222), (0x2222/0x3333) with no gaps once flowing.
4. Simultaneous push/pop at count=1, 10 back-to-back pushes with OutReady=1 -> count stays 1, InReady stays 1, one output per cycle in order.
5. Out-of-range: NUM_SRC=4, SelA=5 -> OutA=0, SelErr=1 next cycle. ErrClr in the same cycle as a new bad select -> SelErr stays 1.
6. Bypass: SelA=4, ResultIn=0xBEEF -> with OPSEL_BYPASS_EN, OutA=0xBEEF and SelErr=0; without it, OutA=0x0000 and SelErr=1.

Source files
------------

// File: rtl/alu_operand_select_if.sv
// Operand-select bus: request side (sources, selects, valid) and the
// registered operand pair handed to the ALU with its own valid/ready.
interface alu_operand_select_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
);
    logic [NUM_SRC*WIDTH-1:0] SrcData;
    logic [WIDTH-1:0]         ResultIn;
    logic [SEL_W-1:0]         SelA;
    logic [SEL_W-1:0]         SelB;
    logic                     Swap;
    logic                     InValid;
    logic                     InReady;
    logic [WIDTH-1:0]         OutA;
    logic [WIDTH-1:0]         OutB;
    logic                     OutValid;
    logic                     OutReady;
    logic                     SelErr;
    logic                     ErrClr;

    modport master (
        output SrcData, ResultIn, SelA, SelB, Swap, InValid, OutReady, ErrClr,
        input  InReady, OutA, OutB, OutValid, SelErr
    );

    modport slave (
        input  SrcData, ResultIn, SelA, SelB, Swap, InValid, OutReady, ErrClr,
        output InReady, OutA, OutB, OutValid, SelErr
    );
endinterface

// File: rtl/alu_operand_select.sv
// Dual ALU operand selector feeding a 2-entry skid FIFO (head + skid).
// Optional macro OPSEL_BYPASS_EN: select index NUM_SRC picks ResultIn.
module alu_operand_select #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input logic                 CLK,
    input logic                 Reset_n,
    alu_operand_select_if.slave bus
);

`ifdef OPSEL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam logic [SEL_W-1:0] RES_IDX = SEL_W'(NUM_SRC);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    fill_t            state, state_nxt;
    logic             in_ready, out_valid;
    logic             push, pop;
    logic             load_head_new, load_head_skid, load_skid;
    logic [WIDTH-1:0] sel_a_p0, sel_b_p0, new_a_p0, new_b_p0;
    logic             bad_p0;
    logic [WIDTH-1:0] head_a_p1, head_b_p1, skid_a_p1, skid_b_p1;
    logic             sel_err;

    function automatic logic [WIDTH-1:0] pick(
        input logic [SEL_W-1:0]         sel,
        input logic [NUM_SRC*WIDTH-1:0] src,
        input logic [WIDTH-1:0]         res
    );
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) v = src[i*WIDTH +: WIDTH];
        end
        if (BYPASS && (sel == RES_IDX)) v = res;
        return v;
    endfunction

    function automatic logic out_of_range(input logic [SEL_W-1:0] sel);
        return BYPASS ? (sel > RES_IDX) : (sel >= RES_IDX);
    endfunction

    // Stage p0: combinational selection of the request being offered
    always_comb begin
        sel_a_p0 = pick(bus.SelA, bus.SrcData, bus.ResultIn);
        sel_b_p0 = pick(bus.SelB, bus.SrcData, bus.ResultIn);
        new_a_p0 = bus.Swap ? sel_b_p0 : sel_a_p0;
        new_b_p0 = bus.Swap ? sel_a_p0 : sel_b_p0;
        bad_p0   = out_of_range(bus.SelA) || out_of_range(bus.SelB);
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = bus.InValid && in_ready;
    assign pop       = out_valid && bus.OutReady;

    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    load_head_new = 1'b1;
                    state_nxt     = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    load_head_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Stage p1: head/skid storage and sticky error flag
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= EMPTY;
            head_a_p1 <= '0;
            head_b_p1 <= '0;
            sel_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_head_new) begin
                head_a_p1 <= new_a_p0;
                head_b_p1 <= new_b_p0;
            end else if (load_head_skid) begin
                head_a_p1 <= skid_a_p1;
                head_b_p1 <= skid_b_p1;
            end
            if (push && bad_p0) sel_err <= 1'b1;
            else if (bus.ErrClr) sel_err <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (load_skid) begin
            skid_a_p1 <= new_a_p0;
            skid_b_p1 <= new_b_p0;
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.OutA     = head_a_p1;
    assign bus.OutB     = head_b_p1;
    assign bus.SelErr   = sel_err;

endmodule

// File: tb/tb_alu_operand_select.sv
// Directed bench for alu_operand_select with a queue-based reference model.
module tb_alu_operand_select;
    logic CLK;
    logic Reset_n;
    int   checks;
    int   failures;

    logic [31:0] mq[$];
    logic        merr;

    alu_operand_select_if #(.WIDTH(16), .NUM_SRC(4)) bus ();

    alu_operand_select #(.WIDTH(16), .NUM_SRC(4)) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pick(input int idx, input logic [63:0] src,
                                              input logic [15:0] res);
        if (idx < 4) return src[idx*16 +: 16];
`ifdef OPSEL_BYPASS_EN
        if (idx == 4) return res;
`endif
        return 16'h0000;
    endfunction

    function automatic bit ref_bad(input int idx);
`ifdef OPSEL_BYPASS_EN
        return idx > 4;
`else
        return idx >= 4;
`endif
    endfunction

    // Reference model: a queue of at most two operand pairs
    initial begin
        logic        do_push, do_pop;
        logic [15:0] a, b;
        merr = 1'b0;
        forever begin
            @(posedge CLK or negedge Reset_n);
            if (!Reset_n) begin
                mq.delete();
                merr = 1'b0;
            end else begin
                do_push = bus.InValid && (mq.size() < 2);
                do_pop  = (mq.size() > 0) && bus.OutReady;
                a = ref_pick(int'(bus.SelA), bus.SrcData, bus.ResultIn);
                b = ref_pick(int'(bus.SelB), bus.SrcData, bus.ResultIn);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(bus.Swap ? {b, a} : {a, b});
                if (do_push && (ref_bad(int'(bus.SelA)) || ref_bad(int'(bus.SelB)))) merr = 1'b1;
                else if (bus.ErrClr) merr = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (Reset_n) begin
                chk("model_out_valid", {31'd0, bus.OutValid}, {31'd0, mq.size() > 0});
                chk("model_in_ready", {31'd0, bus.InReady}, {31'd0, mq.size() < 2});
                chk("model_sel_err", {31'd0, bus.SelErr}, {31'd0, merr});
                if (mq.size() > 0) begin
                    chk("model_out_a", {16'd0, bus.OutA}, {16'd0, mq[0][31:16]});
                    chk("model_out_b", {16'd0, bus.OutB}, {16'd0, mq[0][15:0]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [2:0] sa, input logic [2:0] sb, input logic sw);
        int n;
        @(negedge CLK);
        bus.SelA    = sa;
        bus.SelB    = sb;
        bus.Swap    = sw;
        bus.InValid = 1'b1;
        n = 0;
        while (!bus.InReady && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
        @(posedge CLK);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        Reset_n     = 1'b0;
        bus.SrcData = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        bus.ResultIn = 16'h0000;
        bus.SelA    = '0;
        bus.SelB    = '0;
        bus.Swap    = 1'b0;
        bus.InValid = 1'b0;
        bus.OutReady = 1'b1;
        bus.ErrClr  = 1'b0;
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
        @(negedge CLK);
        chk("rst_in_ready", {31'd0, bus.InReady}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.OutValid}, 32'd0);
        chk("rst_out_a", {16'd0, bus.OutA}, 32'd0);
        chk("rst_sel_err", {31'd0, bus.SelErr}, 32'd0);

        // Basic select, without and with swap
        send(3'd2, 3'd1, 1'b0);
        @(negedge CLK);
        bus.InValid = 1'b0;
        chk("basic_valid", {31'd0, bus.OutValid}, 32'd1);
        chk("basic_a", {16'd0, bus.OutA}, 32'h2222);
        chk("basic_b", {16'd0, bus.OutB}, 32'h1111);
        send(3'd2, 3'd1, 1'b1);
        @(negedge CLK);
        bus.InValid = 1'b0;
        chk("swap_a", {16'd0, bus.OutA}, 32'h1111);
        chk("swap_b", {16'd0, bus.OutB}, 32'h2222);
        @(negedge CLK);
        chk("drain_hold_a", {16'd0, bus.OutA}, 32'h1111);

        // Back-pressure: third request held until the ALU drains
        bus.OutReady = 1'b0;
        send(3'd0, 3'd1, 1'b0);
        send(3'd1, 3'd2, 1'b0);
        @(negedge CLK);
        bus.SelA    = 3'd2;
        bus.SelB    = 3'd3;
        bus.InValid = 1'b1;
        chk("bp_full_ready", {31'd0, bus.InReady}, 32'd0);
        chk("bp_head_a", {16'd0, bus.OutA}, 32'h0000);
        chk("bp_head_b", {16'd0, bus.OutB}, 32'h1111);
        bus.OutReady = 1'b1;
        @(negedge CLK);
        chk("bp_ready_again", {31'd0, bus.InReady}, 32'd1);
        chk("bp_second_a", {16'd0, bus.OutA}, 32'h1111);
        chk("bp_second_b", {16'd0, bus.OutB}, 32'h2222);
        @(negedge CLK);
        bus.InValid = 1'b0;
        chk("bp_third_a", {16'd0, bus.OutA}, 32'h2222);
        chk("bp_third_b", {16'd0, bus.OutB}, 32'h3333);
        repeat (2) @(negedge CLK);

        // Streaming: push and pop every cycle
        for (int k = 0; k < 10; k++) send(3'(k % 4), 3'((k + 1) % 4), 1'(k % 2));
        @(negedge CLK);
        bus.InValid = 1'b0;
        chk("stream_last_a", {16'd0, bus.OutA}, 32'h2222);
        chk("stream_last_b", {16'd0, bus.OutB}, 32'h1111);
        @(negedge CLK);

        // Out-of-range selects and set-beats-clear
        send(3'd5, 3'd1, 1'b0);
        @(negedge CLK);
        chk("oor_a", {16'd0, bus.OutA}, 32'h0000);
        chk("oor_b", {16'd0, bus.OutB}, 32'h1111);
        chk("oor_err", {31'd0, bus.SelErr}, 32'd1);
        bus.SelA   = 3'd0;
        bus.SelB   = 3'd6;
        bus.ErrClr = 1'b1;
        @(negedge CLK);
        chk("oor_set_wins", {31'd0, bus.SelErr}, 32'd1);
        bus.SelB = 3'd1;
        @(negedge CLK);
        chk("oor_cleared", {31'd0, bus.SelErr}, 32'd0);
        bus.ErrClr  = 1'b0;
        bus.InValid = 1'b0;
        @(negedge CLK);

        // Result bypass index
        bus.ResultIn = 16'hBEEF;
        send(3'd4, 3'd3, 1'b0);
        @(negedge CLK);
        bus.InValid  = 1'b0;
        bus.ResultIn = 16'h0000;
`ifdef OPSEL_BYPASS_EN
        chk("byp_a", {16'd0, bus.OutA}, 32'hBEEF);
        chk("byp_err", {31'd0, bus.SelErr}, 32'd0);
`else
        chk("byp_a", {16'd0, bus.OutA}, 32'h0000);
        chk("byp_err", {31'd0, bus.SelErr}, 32'd1);
`endif
        chk("byp_b", {16'd0, bus.OutB}, 32'h3333);
        @(negedge CLK);

        // Asynchronous reset with the buffer full and the error flag set
        bus.OutReady = 1'b0;
        send(3'd7, 3'd1, 1'b0);
        send(3'd1, 3'd2, 1'b0);
        @(negedge CLK);
        bus.InValid = 1'b0;
        chk("pre_rst_full", {31'd0, bus.InReady}, 32'd0);
        chk("pre_rst_err", {31'd0, bus.SelErr}, 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.OutValid}, 32'd0);
        chk("arst_a", {16'd0, bus.OutA}, 32'd0);
        chk("arst_b", {16'd0, bus.OutB}, 32'd0);
        chk("arst_err", {31'd0, bus.SelErr}, 32'd0);
        @(negedge CLK);
        #2 Reset_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", {31'd0, bus.InReady}, 32'd1);
        chk("post_rst_valid", {31'd0, bus.OutValid}, 32'd0);
        bus.OutReady = 1'b1;
        send(3'd3, 3'd0, 1'b0);
        @(negedge CLK);
        chk("post_rst_a", {16'd0, bus.OutA}, 32'h3333);
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
